// File: rtl/audio_avg_filter_pkg.sv
// Shared types and helpers for the stereo moving-average audio filter.
// Contents: FSM state enum, default sample width, sign-extension helper.
package audio_filt_pkg;

  localparam int unsigned DATA_W_DEFAULT = 24;
  localparam int unsigned SEXT_W         = 64;

  typedef enum logic [1:0] {
    S_IN  = 2'd0,
    S_ACC = 2'd1,
    S_OUT = 2'd2
  } state_t;

  // Sign-extend the low w bits of x to 64 bits; callers cast down to the sum width.
  function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] x,
                                                     input int unsigned w);
    logic signed [SEXT_W-1:0] t;
    t = $signed(x << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/audio_avg_filter_channel.sv
// One channel of the boxcar filter: circular delay line, running sum and
// output register. Updated only on load; the write pointer is owned by the top.
// Ports: clk, rst_n, load, bypass, wptr, sample (in), data (filtered out).
module avg_channel
  import audio_filt_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    bypass,
  input  logic [((LOG2_DEPTH == 0) ? 1 : LOG2_DEPTH)-1:0] wptr,
  input  logic [DATA_W-1:0]       sample,
  output logic [DATA_W-1:0]       data
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;

  logic [DATA_W-1:0]        line [DEPTH];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [SUM_W-1:0]  avg;

  // New sum: add the incoming sample, retire the oldest one it overwrites.
  always_comb begin
    sum_next = sum + SUM_W'(sext(SEXT_W'(sample), DATA_W))
                   - SUM_W'(sext(SEXT_W'(line[wptr]), DATA_W));
    avg      = sum_next >>> LOG2_DEPTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) line[i] <= '0;
      sum  <= '0;
      data <= '0;
    end else if (load) begin
      line[wptr] <= sample;
      sum        <= sum_next;
      data       <= bypass ? sample : DATA_W'(avg);
    end
  end

endmodule

// File: rtl/audio_avg_filter.sv
// Stereo moving-average low-pass between the codec read and write ports.
// Sequence per pair: S_IN (read handshake) -> S_ACC (filter update) -> S_OUT
// (write handshake). read/write are combinational strobes gated by state.
// Ports: CLOCK_50, reset_n, read_ready, readdata_left/right, read,
//        write_ready, write, writedata_left/right,
//        bypass (only with AUDIO_AVG_FILTER_BYPASS_EN defined).
// Build option: AUDIO_AVG_FILTER_BYPASS_EN adds the bypass input.
module audio_avg_filter
  import audio_filt_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
`ifdef AUDIO_AVG_FILTER_BYPASS_EN
  input  logic              bypass,
`endif
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);

  localparam int unsigned PTR_W = (LOG2_DEPTH == 0) ? 1 : LOG2_DEPTH;

  state_t            state;
  logic [PTR_W-1:0]  wptr;
  logic [DATA_W-1:0] in_l;
  logic [DATA_W-1:0] in_r;
  logic              load;
  logic              byp;

`ifdef AUDIO_AVG_FILTER_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  // Strobes follow the codec ready lines only in their own state, so they never overlap.
  assign read  = (state == S_IN)  && read_ready;
  assign write = (state == S_OUT) && write_ready;
  assign load  = (state == S_ACC);

  // Handshake FSM, input latch and delay-line pointer.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IN;
      wptr  <= '0;
      in_l  <= '0;
      in_r  <= '0;
    end else begin
      case (state)
        S_IN: begin
          if (read_ready) begin
            in_l  <= readdata_left;
            in_r  <= readdata_right;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          // Window of one entry keeps the pointer at 0.
          wptr  <= (LOG2_DEPTH == 0) ? '0 : wptr + PTR_W'(1);
          state <= S_OUT;
        end
        S_OUT: begin
          if (write_ready) state <= S_IN;
        end
        default: state <= S_IN;
      endcase
    end
  end

  avg_channel #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_left (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .load   (load),
    .bypass (byp),
    .wptr   (wptr),
    .sample (in_l),
    .data   (writedata_left)
  );

  avg_channel #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_right (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .load   (load),
    .bypass (byp),
    .wptr   (wptr),
    .sample (in_r),
    .data   (writedata_right)
  );

endmodule
